pulse_gen: RTL

- Transmit-side counterpart of the pulse-length counter: takes a length word and drives a single-bit pulse exactly that many clk cycles wide.
- Produces the stimulus-style `in` waveform that the length counter consumes; used as a programmable pulse source in front of it.
- Length is accepted over a valid/ready handshake. A guaranteed low gap follows each pulse so the downstream counter can resolve consecutive pulses.

---
 rtl/pulse_pkg.sv | 21 ++
 rtl/pulse_dn_cnt.sv | 28 ++
 rtl/pulse_gen.sv | 111 +++++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the programmable pulse source: state encoding,
// default sizing and the counter-width rule.
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_GAP   = 2;

  // The shared counter must hold both len-1 and GAP-1.
  function automatic int cnt_width(input int cnt_w, input int gap);
    int g;
    g = $clog2(gap);
    return (cnt_w > g) ? cnt_w : g;
  endfunction

endpackage

// File: rtl/pulse_dn_cnt.sv
// Loadable down-counter with a zero flag; shared by the pulse and gap phases.
// Load has priority over decrement, and the count holds at zero.
module pulse_dn_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pulse_gen.sv
// Programmable pulse source: accepts a length over valid/ready and drives a
// registered pulse exactly that many cycles wide, followed by a fixed low gap.
//
// state    | meaning
// ST_IDLE  | ready for a request, out low
// ST_PULSE | out high, counter holds remaining pulse cycles minus one
// ST_GAP   | out low, request blocked, counter holds remaining gap cycles minus one
module pulse_gen
  import pulse_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             len_valid,
  input  logic [CNT_W-1:0] len,
  output logic             len_ready,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(CNT_W, GAP);
  localparam logic [CW-1:0] GAP_M1 = CW'(GAP - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic            r_out;
  logic            r_done;
  logic            w_out_nxt;
  logic            w_done_nxt;
  logic            w_load;
  logic            w_en;
  logic            w_zero;
  logic [CW-1:0]   w_load_val;
  logic [CW-1:0]   w_len_ext;

  assign w_len_ext = CW'(len);

  pulse_dn_cnt #(.W(CW)) u_cnt (
    .clk        (clk),
    .rst_       (rst_),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state <= ST_IDLE;
      r_out   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_load_val  = w_len_ext - CW'(1);
    w_en        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (len_valid) begin
          // A zero length is consumed and acknowledged without a pulse.
          if (len != '0) begin
            w_state_nxt = ST_PULSE;
            w_load      = 1'b1;
            w_out_nxt   = 1'b1;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_PULSE: begin
        if (w_zero) begin
          w_state_nxt = ST_GAP;
          w_load      = 1'b1;
          w_load_val  = GAP_M1;
          w_done_nxt  = 1'b1;
        end else begin
          w_en      = 1'b1;
          w_out_nxt = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_en = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign out       = r_out;
  assign done      = r_done;
  assign len_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);

endmodule
